wire_loopback_checker: RTL and testbench

Synthesizable response checker for the wire-through lab block: it watches the single driven input and the two pass-through outputs of the block under test, compares each output against the expected value of the driven input, and accumulates mismatch and edge statistics. It is the receiving end of the drive pattern: the stimulus side toggles the input, and this block confirms that both outputs follow it. It sits beside the block under test on the same clock.

---
 rtl/wire_loopback_checker.sv | 154 +++++++++++++++
 tb/tb_wire_loopback_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wire_loopback_checker.sv
// Response checker for the wire-through lab block: compares obs_b/obs_c against drv delayed by LATENCY.
// Optional first-mismatch cycle capture is enabled by defining WIRE_CHK_FIRST_ERR_EN.
module wire_loopback_checker #(
  parameter int LATENCY  = 0,
  parameter bit C_INVERT = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             drv,
  input  logic             obs_b,
  input  logic             obs_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] edge_cnt
`ifdef WIRE_CHK_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0] first_err_cyc
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0]       WU_END  = 3'(LATENCY);

  state_e           state_q, state_d;
  logic [2:0]       wu_q, wu_d;
  logic [CNT_W-1:0] err_q, err_d, edge_q, edge_d;
  logic             mis_q, mis_d, pass_q, pass_d;
  logic             drv_prev_q;
  logic             clr, sample, exp_v;
  logic [LATENCY:0] tap;

  // tap[k] is drv delayed k cycles; tap[0] is the live input
  if (LATENCY > 0) begin : g_dly
    logic [LATENCY-1:0] dly_q, dly_d;
    assign dly_d = tap[LATENCY-1:0];
    assign tap   = {dly_q, drv};
    always_ff @(posedge clk or posedge rst) begin
      if (rst) dly_q <= '0;
      else     dly_q <= dly_d;
    end
  end else begin : g_nodly
    assign tap = drv;
  end
  assign exp_v = tap[LATENCY];

`ifdef WIRE_CHK_FIRST_ERR_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, fe_q, fe_d;
`endif

  always_comb begin
    state_d = state_q;
    wu_d    = wu_q;
    err_d   = err_q;
    edge_d  = edge_q;
    pass_d  = pass_q;
    mis_d   = 1'b0;
    clr     = 1'b0;
    sample  = 1'b0;
`ifdef WIRE_CHK_FIRST_ERR_EN
    cyc_d   = cyc_q;
    fe_d    = fe_q;
`endif
    // start has priority over stop in every state
    case (state_q)
      IDLE: if (start) clr = 1'b1;
      RUN: begin
        if (start) clr = 1'b1;
        else if (stop) begin
          state_d = DONE;
          pass_d  = (err_q == '0) && (edge_q != '0);
        end else sample = 1'b1;
      end
      DONE: if (start) clr = 1'b1;
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d = RUN;
      wu_d    = '0;
      err_d   = '0;
      edge_d  = '0;
      pass_d  = 1'b0;
`ifdef WIRE_CHK_FIRST_ERR_EN
      cyc_d   = '0;
      fe_d    = '1;
`endif
    end

    if (sample) begin
      if (drv != drv_prev_q && edge_q != CNT_MAX) edge_d = edge_q + CNT_ONE;
      if (wu_q != WU_END) wu_d = wu_q + 3'd1;
      else if (obs_b != exp_v || obs_c != (exp_v ^ C_INVERT)) begin
        mis_d = 1'b1;
        if (err_q != CNT_MAX) err_d = err_q + CNT_ONE;
`ifdef WIRE_CHK_FIRST_ERR_EN
        if (err_q == '0) fe_d = cyc_q;
`endif
      end
`ifdef WIRE_CHK_FIRST_ERR_EN
      if (cyc_q != CNT_MAX) cyc_d = cyc_q + CNT_ONE;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wu_q       <= '0;
      err_q      <= '0;
      edge_q     <= '0;
      pass_q     <= 1'b0;
      mis_q      <= 1'b0;
      drv_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wu_q       <= wu_d;
      err_q      <= err_d;
      edge_q     <= edge_d;
      pass_q     <= pass_d;
      mis_q      <= mis_d;
      drv_prev_q <= drv;
    end
  end

`ifdef WIRE_CHK_FIRST_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      fe_q  <= '1;
    end else begin
      cyc_q <= cyc_d;
      fe_q  <= fe_d;
    end
  end
  assign first_err_cyc = fe_q;
`endif

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign pass     = pass_q;
  assign mismatch = mis_q;
  assign err_cnt  = err_q;
  assign edge_cnt = edge_q;

endmodule

// File: tb/tb_wire_loopback_checker.sv
// Directed bench: six checker instances with different parameters/observation wiring share one stimulus.
module tb_wire_loopback_checker;
  logic clk = 1'b0;
  logic rst, start, stop, drv, inj;
  logic d1, d2;
  logic        busy_w[6], done_w[6], pass_w[6], mis_w[6];
  logic        obs_b_w[6], obs_c_w[6];
  logic [15:0] err_w[5], edg_w[5], fe_w[5];
  logic [2:0]  err5, edg5, fe5;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  // bench-side delayed copies of drv
  always @(posedge clk) begin
    d1 <= drv;
    d2 <= d1;
  end

  // u0 straight (with injection), u1 delayed 2, u2 delayed 1, u3/u4 obs_c inverted, u5 obs_b stuck 1
  assign obs_b_w[0] = drv ^ inj; assign obs_c_w[0] = drv;
  assign obs_b_w[1] = d2;        assign obs_c_w[1] = d2;
  assign obs_b_w[2] = d1;        assign obs_c_w[2] = d1;
  assign obs_b_w[3] = drv;       assign obs_c_w[3] = ~drv;
  assign obs_b_w[4] = drv;       assign obs_c_w[4] = ~drv;
  assign obs_b_w[5] = 1'b1;      assign obs_c_w[5] = drv;

`ifdef WIRE_CHK_FIRST_ERR_EN
  `define FE_PORT(x) , .first_err_cyc(x)
`else
  `define FE_PORT(x)
`endif

  wire_loopback_checker #(.LATENCY(0), .C_INVERT(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .drv(drv), .obs_b(obs_b_w[0]), .obs_c(obs_c_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .mismatch(mis_w[0]),
    .err_cnt(err_w[0]), .edge_cnt(edg_w[0]) `FE_PORT(fe_w[0]));
  wire_loopback_checker #(.LATENCY(2), .C_INVERT(1'b0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .drv(drv), .obs_b(obs_b_w[1]), .obs_c(obs_c_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .mismatch(mis_w[1]),
    .err_cnt(err_w[1]), .edge_cnt(edg_w[1]) `FE_PORT(fe_w[1]));
  wire_loopback_checker #(.LATENCY(2), .C_INVERT(1'b0), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .drv(drv), .obs_b(obs_b_w[2]), .obs_c(obs_c_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .mismatch(mis_w[2]),
    .err_cnt(err_w[2]), .edge_cnt(edg_w[2]) `FE_PORT(fe_w[2]));
  wire_loopback_checker #(.LATENCY(0), .C_INVERT(1'b1), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .drv(drv), .obs_b(obs_b_w[3]), .obs_c(obs_c_w[3]),
    .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .mismatch(mis_w[3]),
    .err_cnt(err_w[3]), .edge_cnt(edg_w[3]) `FE_PORT(fe_w[3]));
  wire_loopback_checker #(.LATENCY(0), .C_INVERT(1'b0), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .drv(drv), .obs_b(obs_b_w[4]), .obs_c(obs_c_w[4]),
    .busy(busy_w[4]), .done(done_w[4]), .pass(pass_w[4]), .mismatch(mis_w[4]),
    .err_cnt(err_w[4]), .edge_cnt(edg_w[4]) `FE_PORT(fe_w[4]));
  wire_loopback_checker #(.LATENCY(0), .C_INVERT(1'b0), .CNT_W(3)) u5 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .drv(drv), .obs_b(obs_b_w[5]), .obs_c(obs_c_w[5]),
    .busy(busy_w[5]), .done(done_w[5]), .pass(pass_w[5]), .mismatch(mis_w[5]),
    .err_cnt(err5), .edge_cnt(edg5) `FE_PORT(fe5));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // apply inputs, let one rising edge sample them, land 1 ns after the edge
  task automatic cyc(input logic st, input logic sp, input logic d);
    start = st; stop = sp; drv = d;
    @(posedge clk); #1;
  endtask

  logic pat[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; drv = 1'b0; inj = 1'b0;
    #12;
    chk("rst_busy", busy_w[0], 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_pass", pass_w[0], 0);
    chk("rst_mis", mis_w[0], 0);
    chk("rst_err", err_w[0], 0);
    chk("rst_edge", edg_w[0], 0);
`ifdef WIRE_CHK_FIRST_ERR_EN
    chk("rst_fe", fe_w[0], 32'hFFFF);
`endif
    rst = 1'b0;

    cyc(0, 1, 0);
    chk("idle_stop_busy", busy_w[0], 0);
    chk("idle_stop_done", done_w[0], 0);
    cyc(0, 0, 0);

    // basic toggle run on all instances
    cyc(1, 0, 0);
    chk("A_busy", busy_w[0], 1);
    chk("A_err0", err_w[0], 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, pat[i]);
      chk("A_mis", mis_w[0], 0);
    end
    cyc(0, 1, 1);
    chk("A_done", done_w[0], 1);
    chk("A_busy_off", busy_w[0], 0);
    chk("A_err", err_w[0], 0);
    chk("A_edge", edg_w[0], 3);
    chk("A_pass", pass_w[0], 1);
    chk("L2_err", err_w[1], 0);
    chk("L2_pass", pass_w[1], 1);
    chk("L2d1_err", err_w[2], 3);
    chk("L2d1_pass", pass_w[2], 0);
    chk("inv_err", err_w[3], 0);
    chk("inv_pass", pass_w[3], 1);
    chk("noinv_err", err_w[4], 8);
    chk("noinv_pass", pass_w[4], 0);
    cyc(0, 1, 0);
    chk("done_hold", done_w[0], 1);
    chk("done_edge_hold", edg_w[0], 3);
    chk("done_pass_hold", pass_w[0], 1);

    // drv held low: saturation on the 3-bit instance, no edges anywhere
    cyc(1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0);
      if (i == 4) chk("sat_err5", err5, 5);
    end
    chk("sat_err7", err5, 7);
    cyc(0, 1, 0);
    chk("sat_hold", err5, 7);
    chk("sat_edge", edg5, 0);
    chk("sat_pass", pass_w[5], 0);
    chk("noedge_err", err_w[0], 0);
    chk("noedge_pass", pass_w[0], 0);

    // restart and start/stop collision on the always-failing instance
    cyc(1, 0, 0);
    chk("C_mis_start", mis_w[4], 0);
    chk("C_err_start", err_w[4], 0);
    cyc(0, 0, 0);
    chk("C_mis", mis_w[4], 1);
    cyc(0, 0, 0);
    chk("C_err2", err_w[4], 2);
    cyc(1, 0, 0);
    chk("C_restart_err", err_w[4], 0);
    chk("C_restart_mis", mis_w[4], 0);
    chk("C_restart_busy", busy_w[4], 1);
    cyc(0, 0, 0);
    chk("C_err1", err_w[4], 1);
    cyc(1, 1, 0);
    chk("C_both_busy", busy_w[4], 1);
    chk("C_both_done", done_w[4], 0);
    chk("C_both_err", err_w[4], 0);

    // asynchronous reset mid-run
    cyc(0, 0, 0);
    chk("D_err_pre", err_w[4], 1);
    #2 rst = 1'b1;
    #1;
    chk("D_busy", busy_w[4], 0);
    chk("D_err", err_w[4], 0);
    chk("D_mis", mis_w[4], 0);
    rst = 1'b0;

    // single injected mismatch at the fifth RUN sample
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      inj = (i == 4);
      cyc(0, 0, pat[i]);
    end
    inj = 1'b0;
    cyc(0, 1, 1);
    chk("E_err", err_w[0], 1);
    chk("E_pass", pass_w[0], 0);
`ifdef WIRE_CHK_FIRST_ERR_EN
    chk("E_fe", fe_w[0], 4);
`endif
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, pat[i]);
    cyc(0, 1, 1);
    chk("E_clean_err", err_w[0], 0);
    chk("E_clean_pass", pass_w[0], 1);
`ifdef WIRE_CHK_FIRST_ERR_EN
    chk("E_clean_fe", fe_w[0], 32'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
